// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline stall/flush controller. Merges NUM_REQ stall requests into
//   per-stage stall and bubble vectors and issues stage flushes. A flush that
//   collides with a stall from an older stage is held as a pending flush and
//   applied on the first ready cycle where it no longer collides. Also keeps
//   per-source saturating stall counters and a sticky stall-timeout watchdog.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global ready; low freezes the whole pipeline
//   stall_req_i       per-source stall request
//   flush_req_i       flush request
//   flush_stage_i     oldest stage to squash (stages 0..F are flushed)
//   perf_sel_i        counter select (values >= NUM_REQ read 0)
//   perf_clr_i        clear all performance counters
//   stall_o           bit k: hold stage k's pipeline register
//   bubble_o          bit k: load a NOP into stage k
//   flush_o           bit k: squash stage k
//   flush_pending_o   a deferred flush is being held
//   stall_timeout_o   sticky watchdog flag
//   perf_cnt_o        selected counter value
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int STAGE_W    = 3,
   parameter int NUM_REQ    = 4,
   parameter logic [NUM_REQ*STAGE_W-1:0] REQ_STAGE = 12'h4C8,
   parameter int CNT_W      = 16,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic [NUM_REQ-1:0]    stall_req_i,
   input  logic                  flush_req_i,
   input  logic [STAGE_W-1:0]    flush_stage_i,
   input  logic [STAGE_W-1:0]    perf_sel_i,
   input  logic                  perf_clr_i,
   output logic [NUM_STAGES-1:0] stall_o,
   output logic [NUM_STAGES-1:0] bubble_o,
   output logic [NUM_STAGES-1:0] flush_o,
   output logic                  flush_pending_o,
   output logic                  stall_timeout_o,
   output logic [CNT_W-1:0]      perf_cnt_o
);

   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   logic                 pend_reg;
   logic [STAGE_W-1:0]   pend_stage_reg;
   logic [TCNT_W-1:0]    tcnt_reg;
   logic                 timeout_reg;
   logic [NUM_REQ*CNT_W-1:0] cnt_flat;

   logic                 stall_any;
   logic [STAGE_W-1:0]   d_stage;
   logic                 flush_any;
   logic [STAGE_W-1:0]   eff_f;
   logic                 flush_ok;

   // Deepest (oldest) stage requested to stall this cycle.
   always_comb begin
      stall_any = 1'b0;
      d_stage   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stall_req_i[i]) begin
            stall_any = 1'b1;
            if (REQ_STAGE[i*STAGE_W +: STAGE_W] > d_stage)
               d_stage = REQ_STAGE[i*STAGE_W +: STAGE_W];
         end
      end
   end

   // Effective flush: a held flush is max-merged with a new request, since
   // squashing the older boundary also covers the younger one.
   always_comb begin
      flush_any = pend_reg | flush_req_i;
      if (pend_reg && flush_req_i && (flush_stage_i > pend_stage_reg))
         eff_f = flush_stage_i;
      else if (pend_reg)
         eff_f = pend_stage_reg;
      else
         eff_f = flush_stage_i;
      flush_ok = flush_any && (!stall_any || (d_stage <= eff_f));
   end

   always_comb begin
      stall_o  = '0;
      bubble_o = '0;
      flush_o  = '0;
      if (rst) begin
         stall_o = '0;
      end else if (!rdy) begin
         stall_o = '1;
      end else if (flush_ok) begin
         // Stages older than the flush boundary but still stalled keep holding.
         for (int k = 0; k < NUM_STAGES; k++) begin
            flush_o[k] = (k <= int'(eff_f));
            stall_o[k] = stall_any && (k > int'(eff_f)) && (k <= int'(d_stage));
         end
      end else if (stall_any) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            stall_o[k]  = (k <= int'(d_stage));
            bubble_o[k] = (k == int'(d_stage) + 1);
         end
      end
   end

   // Pending flush register. A flush that is not applicable can only occur
   // while a stall is active, so it is captured; otherwise it applies now.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_reg       <= 1'b0;
         pend_stage_reg <= '0;
      end else if (rdy) begin
         if (flush_ok) begin
            pend_reg <= 1'b0;
         end else if (flush_any) begin
            pend_reg       <= 1'b1;
            pend_stage_reg <= eff_f;
         end
      end
   end

   // Per-source saturating stall counters.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gen_cnt
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               cnt_reg <= '0;
            else if (rdy) begin
               if (perf_clr_i)
                  cnt_reg <= '0;
               else if (stall_req_i[gi] && (cnt_reg != '1))
                  cnt_reg <= cnt_reg + 1'b1;
            end
         end
         assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
      end
   endgenerate

   always_comb begin
      perf_cnt_o = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (int'(perf_sel_i) == i)
            perf_cnt_o = cnt_flat[i*CNT_W +: CNT_W];
   end

   // Watchdog: counts consecutive ready stall cycles; the flag rises on the
   // same edge the count reaches TIMEOUT and then sticks until reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt_reg    <= '0;
         timeout_reg <= 1'b0;
      end else if (rdy) begin
         if (stall_any) begin
            if (tcnt_reg != TCNT_W'(TIMEOUT))
               tcnt_reg <= tcnt_reg + 1'b1;
            if (tcnt_reg == TCNT_W'(TIMEOUT - 1))
               timeout_reg <= 1'b1;
         end else begin
            tcnt_reg <= '0;
         end
      end
   end

   assign flush_pending_o = pend_reg;
   assign stall_timeout_o = timeout_reg;

endmodule
